sha3_block_padder: RTL and testbench

//  Upstream stage of the Keccak f-permutation. Accepts the message as 32-bit words, applies

---
 rtl/sha3_block_padder_pkg.sv | 28 ++
 rtl/sha3_block_padder_if.sv | 25 ++
 rtl/sha3_pad_word.sv | 30 +++
 rtl/sha3_block_padder.sv | 108 ++++++++++
 tb/tb_sha3_block_padder.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sha3_block_padder_pkg.sv
// sha3_pkg: shared constants, pad bytes and FSM state encoding for the
// SHA-3 / Keccak block padder.
// Build option: SHA3_DOMAIN_PAD_EN selects the FIPS-202 SHA-3 start byte
// (0x06) instead of the original Keccak start byte (0x01).
package sha3_pkg;

  localparam int RATE_W = 576;
  localparam int WORD_W = 32;
  localparam int WORDS  = RATE_W / WORD_W;

  localparam logic [7:0] PAD_START_KECCAK = 8'h01;
  localparam logic [7:0] PAD_START_SHA3   = 8'h06;
  localparam logic [7:0] PAD_END          = 8'h80;

`ifdef SHA3_DOMAIN_PAD_EN
  localparam logic [7:0] PAD_START = PAD_START_SHA3;
`else
  localparam logic [7:0] PAD_START = PAD_START_KECCAK;
`endif

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    FULL = 2'd2,
    DONE = 2'd3
  } pad_state_e;

endpackage

// File: rtl/sha3_block_padder_if.sv
// Message-in / block-out bus of the padder. master = source + permutation
// side, slave = padder.
interface sha3_block_padder_if;
  import sha3_pkg::*;

  logic [WORD_W-1:0] in;
  logic              in_ready;
  logic              is_last;
  logic [1:0]        byte_num;
  logic              buffer_full;
  logic [RATE_W-1:0] out;
  logic              out_ready;
  logic              out_last;
  logic              f_ack;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready, out_last
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready, out_last
  );
endinterface

// File: rtl/sha3_pad_word.sv
// sha3_pad_word: applies pad10*1 to one 32-bit word.
// Byte 0 is in[31:24]. On the last message word, byte[byte_num] becomes the
// start byte and later bytes are cleared; on the final word of a block the
// end bit 0x80 is OR'd into byte 3 (giving 0x81/0x86 when both coincide).
module sha3_pad_word
  import sha3_pkg::*;
(
  input  logic [WORD_W-1:0] in,
  input  logic [1:0]        byte_num,
  input  logic              is_last,
  input  logic              is_final_word,
  output logic [WORD_W-1:0] word
);

  // Byte substitution for the tail, then the closing end bit.
  always_comb begin
    word = in;
    if (is_last) begin
      for (int b = 0; b < 4; b++) begin
        if (b == int'(byte_num))
          word[31-8*b -: 8] = PAD_START;
        else if (b > int'(byte_num))
          word[31-8*b -: 8] = 8'h00;
      end
    end
    if (is_final_word)
      word[7:0] = word[7:0] | PAD_END;
  end

endmodule

// File: rtl/sha3_block_padder.sv
// sha3_block_padder: packs 32-bit message words into 576-bit rate blocks,
// applies pad10*1 and hands blocks to the permutation via out_ready/f_ack.
// Build option: SHA3_DOMAIN_PAD_EN (see sha3_pkg) picks the start byte.
module sha3_block_padder
  import sha3_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  sha3_block_padder_if.slave bus
);

  localparam logic [4:0] LAST_CNT = 5'(WORDS - 1);

  pad_state_e        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [RATE_W-1:0] shreg_q, shreg_d;
  logic              last_q, last_d;

  logic              accept;
  logic [WORD_W-1:0] pw_in;
  logic              pw_last;
  logic              pw_final;
  logic [WORD_W-1:0] word;

  // In PAD the padder feeds itself zero words; only the one landing in the
  // last slot picks up the end bit.
  assign pw_in    = (state_q == FILL) ? bus.in : '0;
  assign pw_last  = (state_q == FILL) & bus.is_last;
  assign pw_final = (cnt_q == LAST_CNT) & ((state_q == PAD) | pw_last);

  sha3_pad_word u_pad_word (
    .in            (pw_in),
    .byte_num      (bus.byte_num),
    .is_last       (pw_last),
    .is_final_word (pw_final),
    .word          (word)
  );

  assign accept = bus.in_ready & (state_q == FILL);

  // State, counter, block register and last flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      shreg_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
    end
  end

  // Next-state: fill words, self-pad the rest, hold the block until f_ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          shreg_d = {shreg_q[RATE_W-WORD_W-1:0], word};
          if (bus.is_last)
            last_d = 1'b1;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + 5'd1;
            if (bus.is_last)
              state_d = PAD;
          end
        end
      end
      PAD: begin
        shreg_d = {shreg_q[RATE_W-WORD_W-1:0], word};
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = FULL;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      FULL: begin
        // A word presented alongside f_ack is not taken: FILL is only
        // entered on the following cycle.
        if (bus.f_ack) begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = last_q ? DONE : FILL;
        end
      end
      DONE: begin
        // Parked until reset; out_last stays up to flag the pending hash.
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.buffer_full = (state_q != FILL);
  assign bus.out_ready   = (state_q == FULL);
  assign bus.out         = shreg_q;
  assign bus.out_last    = last_q;

endmodule

// File: tb/tb_sha3_block_padder.sv
module tb_sha3_block_padder;
  import sha3_pkg::*;

`ifdef SHA3_DOMAIN_PAD_EN
  localparam logic [31:0] EMPTY_TOP = 32'h06000000;
  localparam logic [31:0] ABC_TOP   = 32'h61626306;
  localparam logic [31:0] T4_BOT    = 32'hAABBCC86;
`else
  localparam logic [31:0] EMPTY_TOP = 32'h01000000;
  localparam logic [31:0] ABC_TOP   = 32'h61626301;
  localparam logic [31:0] T4_BOT    = 32'hAABBCC81;
`endif

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   cyc;
  logic [31:0] held;

  sha3_block_padder_if bif();

  sha3_block_padder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One word per cycle: driven at negedge, taken at the following posedge.
  task automatic put(input logic [31:0] w, input logic last, input logic [1:0] bn);
    bif.in       = w;
    bif.is_last  = last;
    bif.byte_num = bn;
    bif.in_ready = 1'b1;
    @(negedge clk);
    bif.in_ready = 1'b0;
    bif.is_last  = 1'b0;
  endtask

  task automatic ack();
    bif.f_ack = 1'b1;
    @(negedge clk);
    bif.f_ack = 1'b0;
  endtask

  task automatic wait_ready(input int maxc, output int c);
    c = 0;
    while (!bif.out_ready && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (!bif.out_ready) chk("timeout_out_ready", 32'd0, 32'd1);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    bif.in = '0;
    bif.in_ready = 1'b0;
    bif.is_last = 1'b0;
    bif.byte_num = '0;
    bif.f_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_out_ready", 32'(bif.out_ready), 32'd0);
    chk("rst_out_last", 32'(bif.out_last), 32'd0);
    chk("rst_buffer_full", 32'(bif.buffer_full), 32'd0);
    chk("rst_out_zero", 32'(|bif.out), 32'd0);

    // 1: empty message, 17 PAD cycles
    put(32'hFFFFFFFF, 1'b1, 2'd0);
    chk("t1_bf_in_pad", 32'(bif.buffer_full), 32'd1);
    wait_ready(40, cyc);
    chk("t1_latency", 32'(cyc), 32'd17);
    chk("t1_top", bif.out[575:544], EMPTY_TOP);
    chk("t1_mid_zero", 32'(|bif.out[543:32]), 32'd0);
    chk("t1_bot", bif.out[31:0], 32'h00000080);
    chk("t1_out_last", 32'(bif.out_last), 32'd1);
    ack();
    chk("t1_done_ready", 32'(bif.out_ready), 32'd0);
    chk("t1_done_bf", 32'(bif.buffer_full), 32'd1);
    chk("t1_done_last", 32'(bif.out_last), 32'd1);

    // 2: "abc"
    do_reset();
    put(32'h61626300, 1'b1, 2'd3);
    wait_ready(40, cyc);
    chk("t2_latency", 32'(cyc), 32'd17);
    chk("t2_top", bif.out[575:544], ABC_TOP);
    chk("t2_mid_zero", 32'(|bif.out[543:32]), 32'd0);
    chk("t2_bot", bif.out[31:0], 32'h00000080);
    ack();
    bif.in = 32'h12345678;
    bif.in_ready = 1'b1;
    repeat (3) @(negedge clk);
    bif.in_ready = 1'b0;
    chk("t2_done_bf", 32'(bif.buffer_full), 32'd1);
    chk("t2_done_out_zero", 32'(|bif.out), 32'd0);
    chk("t2_done_ready", 32'(bif.out_ready), 32'd0);

    // 3: 18 full words, then a padding-only closing block
    do_reset();
    for (int i = 1; i <= 18; i++) put(32'(i), 1'b0, 2'd0);
    wait_ready(5, cyc);
    chk("t3_latency", 32'(cyc), 32'd0);
    chk("t3_b1_last", 32'(bif.out_last), 32'd0);
    chk("t3_b1_top", bif.out[575:544], 32'h00000001);
    chk("t3_b1_bot", bif.out[31:0], 32'h00000012);
    ack();
    chk("t3_fill_bf", 32'(bif.buffer_full), 32'd0);
    put(32'h12345678, 1'b1, 2'd0);
    wait_ready(40, cyc);
    chk("t3_b2_top", bif.out[575:544], EMPTY_TOP);
    chk("t3_b2_bot", bif.out[31:0], 32'h00000080);
    chk("t3_b2_last", 32'(bif.out_last), 32'd1);

    // 4: last word lands in slot 17 with byte_num=3
    do_reset();
    for (int i = 0; i < 17; i++) put(32'h100 + 32'(i), 1'b0, 2'd0);
    put(32'hAABBCCDD, 1'b1, 2'd3);
    chk("t4_ready_now", 32'(bif.out_ready), 32'd1);
    chk("t4_bot", bif.out[31:0], T4_BOT);
    chk("t4_w16", bif.out[63:32], 32'h00000110);
    chk("t4_top", bif.out[575:544], 32'h00000100);
    chk("t4_last", 32'(bif.out_last), 32'd1);

    // 5: stall while FULL; f_ack + in_ready in same cycle
    do_reset();
    for (int i = 0; i < 18; i++) put(32'h200 + 32'(i), 1'b0, 2'd0);
    held = bif.out[31:0];
    bif.in = 32'h00000055;
    bif.is_last = 1'b0;
    bif.in_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_stall_bf", 32'(bif.buffer_full), 32'd1);
    chk("t5_stall_stable", bif.out[31:0], held);
    chk("t5_stall_ready", 32'(bif.out_ready), 32'd1);
    bif.f_ack = 1'b1;
    @(negedge clk);
    bif.f_ack = 1'b0;
    chk("t5_ack_not_taken", bif.out[31:0], 32'h00000000);
    chk("t5_ack_bf", 32'(bif.buffer_full), 32'd0);
    @(negedge clk);
    bif.in_ready = 1'b0;
    chk("t5_taken_next", bif.out[31:0], 32'h00000055);

    // 6: reset mid-block, then a clean block
    do_reset();
    for (int i = 0; i < 9; i++) put(32'h300 + 32'(i), 1'b0, 2'd0);
    do_reset();
    chk("t6_rst_out_zero", 32'(|bif.out), 32'd0);
    chk("t6_rst_bf", 32'(bif.buffer_full), 32'd0);
    for (int i = 0; i < 18; i++) put(32'hA0 + 32'(i), 1'b0, 2'd0);
    chk("t6_ready", 32'(bif.out_ready), 32'd1);
    chk("t6_top", bif.out[575:544], 32'h000000A0);
    chk("t6_bot", bif.out[31:0], 32'h000000B1);
    chk("t6_last", 32'(bif.out_last), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
